// File: rtl/sort_cmd_driver_pkg.sv
// Shared types and default widths for the sort/compute command driver.
package sort_cmd_driver_pkg;

    localparam int DEF_NUM_W = 4;
    localparam int DEF_RES_W = 6;

    typedef enum logic [1:0] {
        MODE_ADD01 = 2'd0,
        MODE_SUB10 = 2'd1,
        MODE_SUB32 = 2'd2,
        MODE_SUB03 = 2'd3
    } cmd_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } drv_state_e;

endpackage

// File: rtl/sort_cmd_driver_sort4.sv
// Ascending 4-input sort (compare-exchange network) followed by the mode arithmetic
// that yields the expected compute-unit result.
module sort4_expect
    import sort_cmd_driver_pkg::*;
#(
    parameter int NUM_W = DEF_NUM_W,
    parameter int RES_W = DEF_RES_W
) (
    input  logic [4*NUM_W-1:0]       num,
    input  logic [1:0]               mode,
    output logic signed [RES_W-1:0]  expect_val
);

    logic signed [NUM_W-1:0] a [4];
    logic signed [NUM_W-1:0] b [4];
    logic signed [NUM_W-1:0] c [4];
    logic signed [NUM_W-1:0] s [4];
    logic signed [RES_W-1:0] x [4];

    // Swaps only on strict less-than, so equal values keep their order.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a[k] = num[k*NUM_W +: NUM_W];
        end
        b = a;
        if (a[1] < a[0]) begin b[0] = a[1]; b[1] = a[0]; end
        if (a[3] < a[2]) begin b[2] = a[3]; b[3] = a[2]; end
        c = b;
        if (b[2] < b[0]) begin c[0] = b[2]; c[2] = b[0]; end
        if (b[3] < b[1]) begin c[1] = b[3]; c[3] = b[1]; end
        s = c;
        if (c[2] < c[1]) begin s[1] = c[2]; s[2] = c[1]; end
        for (int k = 0; k < 4; k++) begin
            x[k] = {{(RES_W-NUM_W){s[k][NUM_W-1]}}, s[k]};
        end
    end

    always_comb begin
        expect_val = '0;
        case (cmd_mode_e'(mode))
            MODE_ADD01: expect_val = x[0] + x[1];
            MODE_SUB10: expect_val = x[1] - x[0];
            MODE_SUB32: expect_val = x[3] - x[2];
            MODE_SUB03: expect_val = x[0] - x[3];
            default:    expect_val = '0;
        endcase
    end

endmodule

// File: rtl/sort_cmd_driver.sv
// Transmit-side driver: accepts a command, bursts its operands to the compute unit,
// then checks the returned result against a locally computed expectation.
module sort_cmd_driver
    import sort_cmd_driver_pkg::*;
#(
    parameter int NUM_W   = DEF_NUM_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4*NUM_W-1:0]       req_num,
    input  logic [1:0]               req_mode,
    output logic                     in_valid,
    output logic [NUM_W-1:0]         in_number,
    output logic [1:0]               mode,
    input  logic                     out_valid,
    input  logic signed [RES_W-1:0]  out_result,
    output logic                     rsp_valid,
    output logic signed [RES_W-1:0]  rsp_result,
    output logic signed [RES_W-1:0]  rsp_expect,
    output logic                     rsp_pass,
    output logic                     rsp_timeout,
    output logic [7:0]               pass_cnt,
    output logic [7:0]               fail_cnt,
    output logic                     err_stray
);

    // Request handshake: a command transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and the requester must hold req_num/req_mode until then.

    drv_state_e              state, state_nx;
    logic [1:0]              beat;
    logic [7:0]              wait_cnt;
    logic [4*NUM_W-1:0]      num_q;
    logic [1:0]              mode_q;
    logic signed [RES_W-1:0] expect_val;
    logic                    accept;
    logic                    capture;
    logic                    timeout_hit;

    sort4_expect #(.NUM_W(NUM_W), .RES_W(RES_W)) u_expect (
        .num        (num_q),
        .mode       (mode_q),
        .expect_val (expect_val)
    );

    assign accept      = (state == IDLE) && req_valid;
    assign capture     = (state == WAIT) && out_valid;
    assign timeout_hit = (state == WAIT) && !out_valid && (wait_cnt == 8'(TIMEOUT - 1));
    assign rsp_valid   = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        in_valid  = 1'b0;
        in_number = '0;
        mode      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = SEND;
            end
            SEND: begin
                in_valid  = 1'b1;
                in_number = num_q[beat*NUM_W +: NUM_W];
                mode      = mode_q;
                if (beat == 2'd3) state_nx = WAIT;
            end
            WAIT: begin
                if (out_valid || timeout_hit) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat        <= '0;
            wait_cnt    <= '0;
            num_q       <= '0;
            mode_q      <= '0;
            rsp_result  <= '0;
            rsp_expect  <= '0;
            rsp_pass    <= 1'b0;
            rsp_timeout <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            err_stray   <= 1'b0;
        end else begin
            if (accept) begin
                num_q  <= req_num;
                mode_q <= req_mode;
                beat   <= '0;
            end else if (state == SEND) begin
                beat <= beat + 2'd1;
            end

            if (state == SEND)      wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;

            // Response fields load on the edge into RESP so they are valid with the pulse.
            if (capture) begin
                rsp_result  <= out_result;
                rsp_expect  <= expect_val;
                rsp_timeout <= 1'b0;
                rsp_pass    <= (out_result == expect_val);
                if (out_result == expect_val) begin
                    if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
                end else begin
                    if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
                end
            end else if (timeout_hit) begin
                rsp_result  <= '0;
                rsp_expect  <= expect_val;
                rsp_timeout <= 1'b1;
                rsp_pass    <= 1'b0;
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            end

            if (out_valid && (state != WAIT)) err_stray <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sort_cmd_driver.sv
// Directed bench for sort_cmd_driver with hand-computed expected results.
module tb_sort_cmd_driver;
    import sort_cmd_driver_pkg::*;

    localparam int NW = 4;
    localparam int RW = 6;
    localparam int TO = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [4*NW-1:0]       req_num;
    logic [1:0]            req_mode;
    logic                  in_valid;
    logic [NW-1:0]         in_number;
    logic [1:0]            mode;
    logic                  out_valid;
    logic signed [RW-1:0]  out_result;
    logic                  rsp_valid;
    logic signed [RW-1:0]  rsp_result;
    logic signed [RW-1:0]  rsp_expect;
    logic                  rsp_pass;
    logic                  rsp_timeout;
    logic [7:0]            pass_cnt;
    logic [7:0]            fail_cnt;
    logic                  err_stray;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pass = 0;
    int exp_fail = 0;

    sort_cmd_driver #(.NUM_W(NW), .RES_W(RW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_num     (req_num),
        .req_mode    (req_mode),
        .in_valid    (in_valid),
        .in_number   (in_number),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_expect  (rsp_expect),
        .rsp_pass    (rsp_pass),
        .rsp_timeout (rsp_timeout),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .err_stray   (err_stray)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command. delay<0 means the compute unit never answers.
    task automatic run_cmd(input logic [15:0] num, input logic [1:0] md, input int exp_val,
                           input int delay, input int reply, input bit hold_next);
        int  n;
        bit  pass;
        logic [NW-1:0] el;
        req_num   = num;
        req_mode  = md;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("req_ready before accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            el = num[b*NW +: NW];
            check($sformatf("in_valid beat%0d", b), in_valid, 1);
            check($sformatf("in_number beat%0d", b), $signed(in_number), $signed(el));
            check($sformatf("mode beat%0d", b), mode, md);
            check($sformatf("req_ready beat%0d", b), req_ready, 0);
            tick();
        end
        check("in_valid in wait", in_valid, 0);
        if (delay >= 0) begin
            for (int i = 0; i < delay; i++) tick();
            out_valid  = 1'b1;
            out_result = reply[RW-1:0];
            if (hold_next) req_valid = 1'b1;
            tick();
            out_valid  = 1'b0;
            out_result = '0;
            pass = (reply == exp_val);
        end else begin
            n = 0;
            while (!rsp_valid && n < TO + 10) begin tick(); n++; end
            check("timeout latency", n, TO);
            pass = 1'b0;
        end
        if (pass) exp_pass++; else exp_fail++;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_result", rsp_result, (delay >= 0) ? reply : 0);
        check("rsp_expect", rsp_expect, exp_val);
        check("rsp_pass", rsp_pass, pass);
        check("rsp_timeout", rsp_timeout, (delay < 0));
        check("req_ready in resp", req_ready, 0);
        check("pass_cnt", pass_cnt, exp_pass);
        check("fail_cnt", fail_cnt, exp_fail);
        tick();
        check("rsp_valid one cycle", rsp_valid, 0);
        check("req_ready after resp", req_ready, 1);
        check("in_valid after resp", in_valid, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_num = '0; req_mode = '0;
        out_valid = 1'b0; out_result = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset req_ready", req_ready, 1);
        check("reset in_valid", in_valid, 0);
        check("reset in_number", in_number, 0);
        check("reset mode", mode, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_result", rsp_result, 0);
        check("reset pass_cnt", pass_cnt, 0);
        check("reset fail_cnt", fail_cnt, 0);
        check("reset err_stray", err_stray, 0);

        // operands {0,7,-2,3} elem3..0 -> sorted -2,0,3,7
        run_cmd(16'h07E3, 2'd0, -2, 2, -2, 1'b0);
        check("err_stray clean", err_stray, 0);
        run_cmd(16'h07E3, 2'd1, 2, 0, 2, 1'b0);
        run_cmd(16'h07E3, 2'd2, 4, 3, 4, 1'b0);
        run_cmd(16'h07E3, 2'd3, -9, 1, -9, 1'b0);

        // all -8: correct -16, then a wrapped +16 reply
        run_cmd(16'h8888, 2'd0, -16, 1, -16, 1'b0);
        run_cmd(16'h8888, 2'd0, -16, 1, 16, 1'b0);

        // no reply, then reply on the final WAIT cycle
        run_cmd(16'h07E3, 2'd0, -2, -1, 0, 1'b0);
        run_cmd(16'h07E3, 2'd1, 2, TO - 1, 2, 1'b0);

        // reset during beat 2 drops the command and clears stats
        req_num = 16'h07E3; req_mode = 2'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("beat2 in_number", $signed(in_number), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst in_valid", in_valid, 0);
        check("rst req_ready", req_ready, 1);
        check("rst pass_cnt", pass_cnt, 0);
        check("rst fail_cnt", fail_cnt, 0);
        exp_pass = 0;
        exp_fail = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("rst no rsp_valid", seen, 0);
        run_cmd(16'h07E3, 2'd1, 2, 1, 2, 1'b0);

        // stray out_valid in IDLE; request held through RESP
        out_valid = 1'b1; out_result = 6'sd5;
        tick();
        out_valid = 1'b0; out_result = '0;
        check("err_stray set", err_stray, 1);
        repeat (3) tick();
        check("err_stray sticky", err_stray, 1);
        run_cmd(16'h07E3, 2'd2, 4, 1, 4, 1'b1);
        run_cmd(16'h07E3, 2'd3, -9, 0, -9, 1'b0);
        check("err_stray end", err_stray, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
